// File: rtl/edge_evt_pkg.sv
// Shared types for the edge-event arbiter: edge type tag, event record and a small
// helper that turns a detector's rise/fall pair into a tag.
package edge_evt_pkg;

    localparam int EVT_NUM_CH = 4;
    localparam int EVT_CH_W   = $clog2(EVT_NUM_CH);

    typedef enum logic {
        EVT_FALL = 1'b0,
        EVT_RISE = 1'b1
    } edge_type_e;

    typedef struct packed {
        logic [EVT_CH_W-1:0] ch;
        edge_type_e          typ;
    } edge_evt_t;

    // Rise and fall are mutually exclusive per channel, so rise alone selects the tag.
    function automatic edge_type_e edge_type(input logic rise);
        return rise ? EVT_RISE : EVT_FALL;
    endfunction

endpackage

// File: rtl/edge_detect_cell.sv
// One channel's edge detector: a delay flop tracking the input and gated rise/fall strobes.
module edge_detect_cell (
    input  logic clk,
    input  logic rstn,
    input  logic a,
    input  logic rise_en,
    input  logic fall_en,
    output logic rise,
    output logic fall
);

    logic del;

    // Delay resets low so an input already high at reset release reports a rise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            del <= 1'b0;
        end else begin
            del <= a;
        end
    end

    assign rise = ~del & a & rise_en;
    assign fall = del & ~a & fall_en;

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge-event arbiter: per-channel edge detection, one pending slot per channel and
// round-robin delivery onto a single valid/ready event port with drop accounting.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] a_i,
    input  logic [NUM_CH-1:0] rise_en_i,
    input  logic [NUM_CH-1:0] fall_en_i,
    input  logic              clr_i,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [CH_W-1:0]   evt_ch_o,
    output logic              evt_rise_o,
    output logic [NUM_CH-1:0] ovf_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    localparam int SUM_W = CNT_W + $clog2(NUM_CH + 1);

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] hit;
    edge_type_e        hit_typ [NUM_CH];

    logic [NUM_CH-1:0] pend;
    edge_type_e        pend_typ [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;

    logic              load;
    logic              found;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   rr_next;
    logic [NUM_CH-1:0] gnt;
    logic [NUM_CH-1:0] drop;

    logic [SUM_W-1:0]  drop_num;
    logic [SUM_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_sat;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cell
        edge_detect_cell u_cell (
            .clk     (clk),
            .rstn    (rstn),
            .a       (a_i[g]),
            .rise_en (rise_en_i[g]),
            .fall_en (fall_en_i[g]),
            .rise    (rise[g]),
            .fall    (fall[g])
        );

        assign hit[g]     = rise[g] | fall[g];
        assign hit_typ[g] = edge_type(rise[g]);
    end

    assign load = ~evt_valid_o | evt_ready_i;

    // Scan from the farthest offset down so the channel nearest rr_ptr wins last.
    always_comb begin
        int              idx;
        logic [CH_W-1:0] idx_v;
        found = 1'b0;
        gnt_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_v = CH_W'(idx);
            if (pend[idx_v]) begin
                found  = 1'b1;
                gnt_ch = idx_v;
            end
        end
    end

    assign rr_next = (int'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + CH_W'(1);

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            gnt[c]  = load & found & (gnt_ch == CH_W'(c));
            drop[c] = hit[c] & pend[c] & ~gnt[c];
        end
    end

    // A slot freed by this cycle's grant can take this cycle's new edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pend_typ[c] <= EVT_FALL;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hit[c] && (!pend[c] || gnt[c])) begin
                    pend[c]     <= 1'b1;
                    pend_typ[c] <= hit_typ[c];
                end else if (gnt[c]) begin
                    pend[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_valid_o <= 1'b0;
            evt_ch_o    <= '0;
            evt_rise_o  <= 1'b0;
            rr_ptr      <= '0;
        end else if (load) begin
            if (found) begin
                evt_valid_o <= 1'b1;
                evt_ch_o    <= gnt_ch;
                evt_rise_o  <= (pend_typ[gnt_ch] == EVT_RISE);
                rr_ptr      <= rr_next;
            end else begin
                evt_valid_o <= 1'b0;
            end
        end
    end

    always_comb begin
        drop_num = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            drop_num = drop_num + SUM_W'(drop[c]);
        end
        cnt_sum = SUM_W'(drop_cnt_o) + drop_num;
        cnt_sat = (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // Clear wins over a drop in the same cycle; that drop is simply forgotten.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_o      <= '0;
            drop_cnt_o <= '0;
        end else if (clr_i) begin
            ovf_o      <= '0;
            drop_cnt_o <= '0;
        end else begin
            ovf_o      <= ovf_o | drop;
            drop_cnt_o <= cnt_sat;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: a behavioural model queues expected events,
// a negedge monitor pops them on each handshake and checks flags and drop count.
module tb_edge_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 2;
    localparam int CNT_MAX = 255;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NUM_CH-1:0] a_i = '0;
    logic [NUM_CH-1:0] rise_en_i = '1;
    logic [NUM_CH-1:0] fall_en_i = '1;
    logic              clr_i = 1'b0;
    logic              evt_ready_i = 1'b1;
    logic              evt_valid_o;
    logic [CH_W-1:0]   evt_ch_o;
    logic              evt_rise_o;
    logic [NUM_CH-1:0] ovf_o;
    logic [CNT_W-1:0]  drop_cnt_o;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int ch;
        bit rise;
    } exp_t;

    exp_t exp_q[$];

    bit          m_full [NUM_CH];
    bit          m_rise [NUM_CH];
    bit          m_prev [NUM_CH];
    int          m_next;
    bit          m_busy;
    bit [NUM_CH-1:0] m_ovf;
    int          m_cnt;

    edge_event_arbiter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .a_i         (a_i),
        .rise_en_i   (rise_en_i),
        .fall_en_i   (fall_en_i),
        .clr_i       (clr_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_ch_o    (evt_ch_o),
        .evt_rise_o  (evt_rise_o),
        .ovf_o       (ovf_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end else begin
            passes++;
        end
    endtask

    // Model: one slot per channel, round-robin next pointer, one output holding register.
    always @(posedge clk or negedge rstn) begin
        bit can_load;
        int granted;
        int drops;
        int c;
        bit re;
        bit fe;
        exp_t e;
        if (!rstn) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_full[k] = 0;
                m_rise[k] = 0;
                m_prev[k] = 0;
            end
            m_next = 0;
            m_busy = 0;
            m_ovf  = '0;
            m_cnt  = 0;
            exp_q.delete();
        end else begin
            can_load = !m_busy || evt_ready_i;
            granted = -1;
            if (can_load) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    c = (m_next + k) % NUM_CH;
                    if (granted < 0 && m_full[c]) granted = c;
                end
            end
            if (granted >= 0) begin
                e.ch = granted;
                e.rise = m_rise[granted];
                exp_q.push_back(e);
                m_full[granted] = 0;
                m_next = (granted + 1) % NUM_CH;
                m_busy = 1;
            end else if (can_load) begin
                m_busy = 0;
            end
            drops = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                re = !m_prev[k] && a_i[k] && rise_en_i[k];
                fe = m_prev[k] && !a_i[k] && fall_en_i[k];
                if (re || fe) begin
                    if (m_full[k]) begin
                        drops++;
                        m_ovf[k] = 1;
                    end else begin
                        m_full[k] = 1;
                        m_rise[k] = re;
                    end
                end
                m_prev[k] = a_i[k];
            end
            if (clr_i) begin
                m_ovf = '0;
                m_cnt = 0;
            end else begin
                m_cnt = (m_cnt + drops > CNT_MAX) ? CNT_MAX : m_cnt + drops;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            check_output("valid", 32'(evt_valid_o), 32'(m_busy));
            check_output("ovf", 32'(ovf_o), 32'(m_ovf));
            check_output("drop_cnt", 32'(drop_cnt_o), 32'(m_cnt));
            if (evt_valid_o && evt_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_event", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_output("evt_ch", 32'(evt_ch_o), 32'(e.ch));
                    check_output("evt_rise", 32'(evt_rise_o), 32'(e.rise));
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [NUM_CH-1:0] a, input logic [NUM_CH-1:0] ren,
                                  input logic [NUM_CH-1:0] fen, input logic rdy,
                                  input logic clr, input int cycles);
        a_i = a;
        rise_en_i = ren;
        fall_en_i = fen;
        evt_ready_i = rdy;
        clr_i = clr;
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        check_output("rst_valid", 32'(evt_valid_o), 32'(0));
        check_output("rst_ch", 32'(evt_ch_o), 32'(0));
        check_output("rst_rise", 32'(evt_rise_o), 32'(0));
        check_output("rst_ovf", 32'(ovf_o), 32'(0));
        check_output("rst_cnt", 32'(drop_cnt_o), 32'(0));
    endtask

    task automatic pulse_reset(input int cycles);
        rstn = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
        rstn = 1'b1;
    endtask

    initial begin
        int   budget;
        logic [NUM_CH-1:0] ra;
        logic [NUM_CH-1:0] rr;
        logic [NUM_CH-1:0] rf;

        // Input high through reset produces a rise as soon as reset lifts.
        a_i = 4'b0001;
        repeat (2) @(posedge clk);
        #2;
        check_reset_values();
        @(posedge clk);
        #2;
        rstn = 1'b1;
        apply_stimulus(4'b0001, 4'hF, 4'hF, 1'b1, 1'b0, 5);

        $display("[TB] single channel rise then fall");
        apply_stimulus(4'b0011, 4'hF, 4'hF, 1'b1, 1'b0, 1);
        apply_stimulus(4'b0001, 4'hF, 4'hF, 1'b1, 1'b0, 5);

        $display("[TB] simultaneous bursts");
        apply_stimulus(4'b0000, 4'hF, 4'hF, 1'b1, 1'b0, 4);
        apply_stimulus(4'b1111, 4'hF, 4'hF, 1'b1, 1'b0, 7);
        apply_stimulus(4'b0000, 4'hF, 4'hF, 1'b1, 1'b0, 7);

        $display("[TB] stalled consumer with drops, then clear");
        apply_stimulus(4'b0100, 4'hF, 4'hF, 1'b0, 1'b0, 1);
        apply_stimulus(4'b0000, 4'hF, 4'hF, 1'b0, 1'b0, 1);
        apply_stimulus(4'b0100, 4'hF, 4'hF, 1'b0, 1'b0, 5);
        apply_stimulus(4'b0100, 4'hF, 4'hF, 1'b0, 1'b1, 1);
        apply_stimulus(4'b0100, 4'hF, 4'hF, 1'b1, 1'b0, 6);

        $display("[TB] drop counter saturation");
        for (int i = 0; i < 300; i++) begin
            apply_stimulus((i % 2 == 0) ? 4'b0000 : 4'b0100, 4'hF, 4'hF, 1'b0, 1'b0, 1);
        end
        apply_stimulus(4'b0000, 4'hF, 4'hF, 1'b0, 1'b1, 1);
        apply_stimulus(4'b0000, 4'hF, 4'hF, 1'b1, 1'b0, 6);

        $display("[TB] enables and mid-burst reset");
        apply_stimulus(4'b1000, 4'hF, 4'b0111, 1'b1, 1'b0, 5);
        apply_stimulus(4'b0000, 4'hF, 4'b0111, 1'b1, 1'b0, 5);
        apply_stimulus(4'b0001, 4'hF, 4'hF, 1'b0, 1'b0, 2);
        apply_stimulus(4'b1001, 4'hF, 4'hF, 1'b0, 1'b0, 1);
        apply_stimulus(4'b1001, 4'h0, 4'hF, 1'b0, 1'b0, 3);
        apply_stimulus(4'b1001, 4'h0, 4'hF, 1'b1, 1'b0, 6);
        apply_stimulus(4'b0000, 4'hF, 4'hF, 1'b1, 1'b0, 6);
        apply_stimulus(4'b1111, 4'hF, 4'hF, 1'b0, 1'b0, 2);
        apply_stimulus(4'b0000, 4'hF, 4'hF, 1'b0, 1'b0, 2);
        rstn = 1'b0;
        check_reset_values();
        @(posedge clk);
        #2;
        rstn = 1'b1;
        apply_stimulus(4'b0000, 4'hF, 4'hF, 1'b1, 1'b0, 6);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            ra = NUM_CH'($urandom);
            rr = NUM_CH'($urandom) | NUM_CH'($urandom);
            rf = NUM_CH'($urandom) | NUM_CH'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset(1);
            end
            apply_stimulus(ra, rr, rf, ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0), 1);
        end

        apply_stimulus(a_i, 4'hF, 4'hF, 1'b1, 1'b0, 1);
        budget = 0;
        while ((m_busy || m_full[0] || m_full[1] || m_full[2] || m_full[3]) && budget < 50) begin
            apply_stimulus(a_i, 4'hF, 4'hF, 1'b1, 1'b0, 1);
            budget++;
        end
        check_output("drain_timeout", 32'(budget >= 50), 32'(0));
        @(negedge clk);
        check_output("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
